// File: rtl/aes_key_expand_seq.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expand_seq
// Function : Sequential AES key-schedule engine. It stores one expanded word
//            per clock into the flat round-key bus that the round datapath
//            indexes. Parameters select AES-128/192/256.
// Option   : KEXP_ROUND_STREAM_EN - when defined, each 128-bit round key is
//            also emitted on rk_valid/rk_index/rk_data as soon as it completes.
// Revision : 1.0 - initial release
// ============================================================================
module aes_key_expand_seq #(
    parameter int NK = 6,   // key length in 32-bit words (4, 6 or 8)
    parameter int NR = 12,  // number of rounds (10, 12 or 14)
    parameter int NB = 4    // state columns, fixed at 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [32*NK-1:0]      key_in,
    output logic                  busy,
    output logic                  done,
    output logic                  exp_key_valid,
    output logic [128*(NR+1)-1:0] exp_key,
    output logic                  rk_valid,
    output logic [3:0]            rk_index,
    output logic [127:0]          rk_data
);

    // Total schedule words and the width of the word counter.
    localparam int NW = NB * (NR + 1);
    localparam int IW = $clog2(NW);

    // AES forward S-box. Byte b sits at bit offset (255-b)*8, i.e. entry 0
    // occupies the MSBs, so the row layout matches the usual printed table.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        FIN    = 2'd2
    } state_t;

    // Only the three standard key/round pairings are supported.
    if (!(((NK == 4) && (NR == 10)) ||
          ((NK == 6) && (NR == 12)) ||
          ((NK == 8) && (NR == 14))) || (NB != 4)) begin : g_param_check
        $error("aes_key_expand_seq: unsupported NK/NR/NB combination");
    end

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------
    // {~b, 3'b000} equals (255-b)*8, the bit offset of entry b.
    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_byte(w[31:24]), sbox_byte(w[23:16]),
                sbox_byte(w[15:8]),  sbox_byte(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [IW-1:0] i_q, i_d;        // index of the word stored at the next edge
    logic [2:0]    j_q, j_d;        // i mod NK, kept as a wrapping counter
    logic [7:0]    rcon_q, rcon_d;
    logic          valid_q, valid_d;
    // Sliding window of the last NK words: win[0] = w[i-NK], win[NK-1] = w[i-1].
    // Keeping it separate avoids two variable-index reads of the big bus.
    logic [31:0]   win_q [NK];
    logic [31:0]   win_d [NK];
    logic [31:0]   w_q   [NW];
    logic [31:0]   w_d   [NW];
    logic [31:0]   temp;
    logic [31:0]   w_new;

    // Next schedule word from the window (S-box path is purely combinational).
    always_comb begin
        temp = win_q[NK-1];
        if (j_q == 3'd0) begin
            temp = sub_word({win_q[NK-1][23:0], win_q[NK-1][31:24]})
                   ^ {rcon_q, 24'h000000};
        end else if ((NK > 6) && (j_q == 3'd4)) begin
            temp = sub_word(win_q[NK-1]);
        end
        w_new = win_q[0] ^ temp;
    end

    // Next-state and datapath update for IDLE -> EXPAND -> FIN -> IDLE.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        rcon_d  = rcon_q;
        valid_d = valid_q;
        win_d   = win_q;
        w_d     = w_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int k = 0; k < NK; k++) begin
                        win_d[k] = key_in[32*(NK-1-k) +: 32];
                        w_d[k]   = key_in[32*(NK-1-k) +: 32];
                    end
                    i_d     = IW'(NK);
                    j_d     = 3'd0;
                    rcon_d  = 8'h01;
                    valid_d = 1'b0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                w_d[i_q] = w_new;
                for (int k = 0; k < NK - 1; k++) begin
                    win_d[k] = win_q[k+1];
                end
                win_d[NK-1] = w_new;
                i_d = i_q + 1'b1;
                j_d = (j_q == 3'(NK - 1)) ? 3'd0 : j_q + 3'd1;
                if (j_q == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (i_q == IW'(NW - 1)) begin
                    valid_d = 1'b1;
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; async reset aborts any expansion in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            rcon_q  <= 8'h01;
            valid_q <= 1'b0;
            for (int k = 0; k < NK; k++) begin
                win_q[k] <= '0;
            end
            for (int k = 0; k < NW; k++) begin
                w_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            rcon_q  <= rcon_d;
            valid_q <= valid_d;
            win_q   <= win_d;
            w_q     <= w_d;
        end
    end

    assign busy          = (state_q == EXPAND);
    assign done          = (state_q == FIN);
    assign exp_key_valid = valid_q;

    // Word w[i] lands MSB-first: w[0] at the top of the bus.
    for (genvar g = 0; g < NW; g++) begin : g_pack
        assign exp_key[32*(NW-1-g) +: 32] = w_q[g];
    end

`ifdef KEXP_ROUND_STREAM_EN
    logic         rk_valid_q, rk_valid_d;
    logic [3:0]   rk_index_q, rk_index_d;
    logic [127:0] rk_data_q,  rk_data_d;

    // Emit a round key whenever its fourth word becomes known.
    always_comb begin
        rk_valid_d = 1'b0;
        rk_index_d = rk_index_q;
        rk_data_d  = rk_data_q;
        if ((state_q == IDLE) && start) begin
            rk_valid_d = 1'b1;
            rk_index_d = 4'd0;
            rk_data_d  = key_in[32*NK-1 -: 128];
        end else if (state_q == EXPAND) begin
            if ((NK > 7) && (i_q == IW'(NK))) begin
                // AES-256 round 1 is all key material; the window still
                // holds it untouched on the first expand edge.
                rk_valid_d = 1'b1;
                rk_index_d = 4'd1;
                rk_data_d  = {win_q[NK-4], win_q[NK-3], win_q[NK-2], win_q[NK-1]};
            end else if (i_q[1:0] == 2'b11) begin
                rk_valid_d = 1'b1;
                rk_index_d = 4'(i_q >> 2);
                rk_data_d  = {win_q[NK-3], win_q[NK-2], win_q[NK-1], w_new};
            end
        end
    end

    // Round-key stream registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_valid_q <= 1'b0;
            rk_index_q <= 4'd0;
            rk_data_q  <= '0;
        end else begin
            rk_valid_q <= rk_valid_d;
            rk_index_q <= rk_index_d;
            rk_data_q  <= rk_data_d;
        end
    end

    assign rk_valid = rk_valid_q;
    assign rk_index = rk_index_q;
    assign rk_data  = rk_data_q;
`else
    assign rk_valid = 1'b0;
    assign rk_index = 4'd0;
    assign rk_data  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_expand_seq
// Function : Self-checking bench for aes_key_expand_seq (NK=6, NR=12) against
//            an algebraic key-schedule model and a cycle phase model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_key_expand_seq;

    localparam int NK  = 6;
    localparam int NR  = 12;
    localparam int NW  = 4 * (NR + 1);
    localparam int TOT = 128 * (NR + 1);
    localparam logic [191:0] KEY1 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] KEY4 = 128'h000102030405060708090a0b0c0d0e0f;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [32*NK-1:0] key_in = '0;
    logic             busy, done, exp_key_valid;
    logic [TOT-1:0]   exp_key;
    logic             rk_valid;
    logic [3:0]       rk_index;
    logic [127:0]     rk_data;

    aes_key_expand_seq #(.NK(NK), .NR(NR), .NB(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .key_in        (key_in),
        .busy          (busy),
        .done          (done),
        .exp_key_valid (exp_key_valid),
        .exp_key       (exp_key),
        .rk_valid      (rk_valid),
        .rk_index      (rk_index),
        .rk_data       (rk_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int rk_cnt = 0;
    logic [7:0] tb_sbox [256];

    // ---------------- algebraic reference ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int n = 0; n < 8; n++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            tb_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                         ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub32(input logic [31:0] t);
        return {tb_sbox[t[31:24]], tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]]};
    endfunction

    // Word j of the schedule is returned at [32*j +: 32]; key word 0 at key[255:224].
    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [79:0]   rc_tab;
        logic [1919:0] res;
        rc_tab = 80'h01020408102040801b36;
        for (int j = 0; j < 60; j++) w[j] = '0;
        for (int j = 0; j < nk; j++) w[j] = key[255-32*j -: 32];
        for (int j = nk; j < 4 * (nr + 1); j++) begin
            t = w[j-1];
            if (j % nk == 0)
                t = sub32({t[23:0], t[31:24]}) ^ {rc_tab[79-8*(j/nk-1) -: 8], 24'h0};
            else if (nk > 6 && j % nk == 4)
                t = sub32(t);
            w[j] = w[j-nk] ^ t;
        end
        res = '0;
        for (int j = 0; j < 60; j++) res[32*j +: 32] = w[j];
        return res;
    endfunction

    function automatic logic [127:0] rk_of(input logic [1919:0] s, input int r);
        return {s[32*(4*r) +: 32], s[32*(4*r+1) +: 32], s[32*(4*r+2) +: 32], s[32*(4*r+3) +: 32]};
    endfunction

    function automatic logic [191:0] rand192();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- cycle model ----------------
    // m_phase: -1 idle; p>=0 means p edges have passed since the accepting edge.
    int             m_phase = -1;
    logic           m_valid = 1'b0;
    logic [TOT-1:0] m_exp = '0;
    logic [1919:0]  m_sched = '0;
`ifdef KEXP_ROUND_STREAM_EN
    logic           m_rkv = 1'b0;
    logic [3:0]     m_rki = 4'd0;
    logic [127:0]   m_rkd = '0;
`endif

    always @(posedge clk or negedge rst_n) begin
        int j;
        if (!rst_n) begin
            m_phase = -1; m_valid = 1'b0; m_exp = '0;
`ifdef KEXP_ROUND_STREAM_EN
            m_rkv = 1'b0;
`endif
        end else begin
`ifdef KEXP_ROUND_STREAM_EN
            m_rkv = 1'b0;
`endif
            if (m_phase < 0) begin
                if (start) begin
                    m_sched = expand({key_in, 64'h0}, NK, NR);
                    m_phase = 0;
                    m_valid = 1'b0;
                    for (int k = 0; k < NK; k++) m_exp[TOT-1-32*k -: 32] = m_sched[32*k +: 32];
`ifdef KEXP_ROUND_STREAM_EN
                    m_rkv = 1'b1; m_rki = 4'd0; m_rkd = rk_of(m_sched, 0);
`endif
                end
            end else if (m_phase == NW - NK) begin
                m_phase = -1;
            end else begin
                m_phase = m_phase + 1;
                j = NK + m_phase - 1;
                m_exp[TOT-1-32*j -: 32] = m_sched[32*j +: 32];
                if (m_phase == NW - NK) m_valid = 1'b1;
`ifdef KEXP_ROUND_STREAM_EN
                if (j % 4 == 3) begin
                    m_rkv = 1'b1; m_rki = 4'(j / 4); m_rkd = rk_of(m_sched, j / 4);
                end
`endif
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, want, $time);
        end
    endtask

    task automatic chk_exp(input string nm, input logic [TOT-1:0] want);
        total++;
        if (exp_key !== want) begin
            bad++;
            for (int j = 0; j < NW; j++) begin
                if (exp_key[TOT-1-32*j -: 32] !== want[TOT-1-32*j -: 32]) begin
                    $display("FAIL %s: word %0d got %h want %h (t=%0t)", nm, j,
                             exp_key[TOT-1-32*j -: 32], want[TOT-1-32*j -: 32], $time);
                    break;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("busy", 128'(busy), 128'(m_phase >= 0 && m_phase < NW - NK));
        chk("done", 128'(done), 128'(m_phase == NW - NK));
        chk("exp_key_valid", 128'(exp_key_valid), 128'(m_valid));
        chk_exp("exp_key", m_exp);
`ifdef KEXP_ROUND_STREAM_EN
        chk("rk_valid", 128'(rk_valid), 128'(m_rkv));
        if (m_rkv) begin
            chk("rk_index", 128'(rk_index), 128'(m_rki));
            chk("rk_data", rk_data, m_rkd);
            if (rk_valid) rk_cnt++;
        end
`else
        chk("rk_valid_off", 128'(rk_valid), 128'(1'b0));
        chk("rk_index_off", 128'(rk_index), 128'(4'd0));
        chk("rk_data_off", rk_data, 128'h0);
`endif
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_start(input logic [191:0] k);
        key_in = k; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 2 * NW) begin
            key_in = rand192();
            tick();
            n++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL done_timeout: got busy=%b want done=1 within %0d cycles", busy, 2 * NW);
        end
    endtask

    task automatic chk_final_key1(input string tag);
        chk({tag, "_round1"}, exp_key[TOT-1-128 -: 128], 128'h10111213141516175846f2f95c43f4fe);
        chk({tag, "_round12"}, exp_key[127:0], 128'ha4970a331a78dc09c418c271e3a41d5d);
        chk({tag, "_valid"}, 128'(exp_key_valid), 128'(1'b1));
    endtask

    initial begin
        logic [1919:0] s;
        int n, d0, off;
        build_sbox();

        // Pin the reference against known answers.
        chk("pin_sbox00", 128'(tb_sbox[8'h00]), 128'h63);
        chk("pin_sbox53", 128'(tb_sbox[8'h53]), 128'hed);
        s = expand({KEY1, 64'h0}, 6, 12);
        chk("pin192_r1", rk_of(s, 1), 128'h10111213141516175846f2f95c43f4fe);
        chk("pin192_r12", rk_of(s, 12), 128'ha4970a331a78dc09c418c271e3a41d5d);
        s = expand({KEY4, 128'h0}, 4, 10);
        chk("pin128_r1", rk_of(s, 1), 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        chk("pin128_r10", rk_of(s, 10), 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Reset state.
        #3 rst_n = 1'b0;
        #1;
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_done", 128'(done), 128'(1'b0));
        chk("rst_valid", 128'(exp_key_valid), 128'(1'b0));
        chk("rst_rk_valid", 128'(rk_valid), 128'(1'b0));
        chk_exp("rst_exp_key", '0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        // Basic AES-192 run with latency check.
        d0 = done_cnt;
        rk_cnt = 0;
        do_start(KEY1);
        wait_done(n);
        chk("latency1", 128'(n), 128'(NW - NK));
        chk_final_key1("run1");
        tick(); tick();
        chk("done_pulses1", 128'(done_cnt - d0), 128'd1);
`ifdef KEXP_ROUND_STREAM_EN
        chk("rk_pulses1", 128'(rk_cnt), 128'(NR + 1));
`endif

        // Start pulse mid-run with a new key must be ignored.
        d0 = done_cnt;
        do_start(KEY1);
        repeat (9) tick();
        key_in = rand192(); start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(n);
        chk("latency_stray", 128'(n + 10), 128'(NW - NK));
        chk_final_key1("stray");
        tick(); tick();
        chk("done_pulses_stray", 128'(done_cnt - d0), 128'd1);

        // Reset mid-expansion aborts with no done pulse.
        d0 = done_cnt;
        do_start(KEY1);
        repeat (19) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 128'(busy), 128'(1'b0));
        chk("abort_valid", 128'(exp_key_valid), 128'(1'b0));
        chk_exp("abort_exp_key", '0);
        tick();
        #3 rst_n = 1'b1;
        repeat (NW) tick();
        chk("abort_no_done", 128'(done_cnt - d0), 128'd0);
        do_start(KEY1);
        wait_done(n);
        chk("latency_after_rst", 128'(n), 128'(NW - NK));
        chk_final_key1("after_rst");

        // Back-to-back random keys: start held through FIN, stray starts mid-run.
        for (int r = 0; r < 6; r++) begin
            d0 = done_cnt;
            key_in = rand192(); start = 1'b1;
            tick();                       // FIN edge: must be ignored
            tick();                       // IDLE edge: accepted
            start = 1'b0;
            off = $urandom_range(1, 40);
            repeat (off - 1) begin key_in = rand192(); tick(); end
            key_in = rand192(); start = 1'b1;
            tick();
            start = 1'b0;
            wait_done(n);
            chk("latency_rand", 128'(n + off), 128'(NW - NK));
            chk("done_pulses_rand", 128'(done_cnt - d0), 128'd1);
        end
        repeat ($urandom_range(1, 3)) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
